result_sat_fifo: RTL and testbench
==================================

// Module: result_sat_fifo
// PURPOSE
//  Output stage of the multiplier datapath. Accepts wide (2*W+1 bit) results and range-checks each one
//  against the W-bit output. Out-of-range results are saturated, wrapped, zeroed or dropped, selected
//  at run time. Results are buffered in a DEPTH-entry FIFO with valid/ready on both sides, and an
//  overflow event counter is kept. Sits between the accumulator and the result readout bus.
// PARAMETERS
//  DATA_WIDTH  8                 output result width W
//  IN_WIDTH    2*DATA_WIDTH+1    input result width; must be > DATA_WIDTH
//  DEPTH       4                 FIFO entries; power of 2, >= 2
//  CNT_WIDTH   8                 overflow counter width
// PORTS
//  clk          in   1                    clock, rising edge
//  reset_n      in   1                    asynchronous reset, active-low
//  in_valid     in   1                    producer has a result
//  in_ready     out  1                    block can accept; = !full
//  in_data      in   IN_WIDTH             unsigned result from datapath
//  sat_mode     in   2                    00 SAT, 01 WRAP, 10 ZERO, 11 DROP
//  out_valid    out  1                    head entry valid
//  out_ready    in   1                    consumer takes head entry
//  out_data     out  DATA_WIDTH           head entry data
//  out_invalid  out  1                    head entry was out of range
//  full         out  1                    count == DEPTH
//  empty        out  1                    count == 0
//  level        out  $clog2(DEPTH)+1      entries held
//  ovf_count    out  CNT_WIDTH            out-of-range results accepted since reset/clear
//  clr_count    in   1                    synchronous clear of ovf_count
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_invalid=0, level=0, empty=1, full=0, ovf_count=0, pointers=0.
//    No output is ever driven to z or x.
//  - Accept: when in_valid && in_ready at a rising edge. in_ready depends only on full, not on out_ready.
//  - Range: ovf = (in_data > 2**DATA_WIDTH-1). For W=8, 255 is in range; 256 and above are out of range.
//  - Mapping when ovf=1: SAT stores all-ones; WRAP stores in_data[W-1:0]; ZERO stores 0.
//    In all three, the stored flag is 1.
//  - DROP (mode 11) with ovf=1: the result is accepted (handshake completes), not written, and counted.
//  - In-range results store in_data[W-1:0] with flag 0 in every mode.
//  - sat_mode is sampled with the accepted beat. Changing it never alters entries already stored.
//  - Latency: a push into an empty FIFO gives out_valid=1 on the next cycle.
//  - Output: out_data and out_invalid are registered and show the head entry while out_valid=1.
//    They hold their value while out_valid && !out_ready.
//  - Pop: on out_valid && out_ready.
//  - Simultaneous push and pop: level unchanged. With level==1, the new entry becomes head next cycle
//    and out_valid stays 1.
//  - Full: in_ready=0 and in_data is ignored. A pop on a full FIFO raises in_ready on the next cycle only.
//  - Empty: out_ready is ignored. out_data keeps its last value, out_invalid=0.
//  - Pointers wrap modulo DEPTH, with no bubble at the wrap point.
//  - ovf_count: +1 per accepted beat with ovf=1 (any mode). Saturates at all-ones and does not wrap.
//  - clr_count: sets ovf_count to 0. If an ovf beat arrives in the same cycle, ovf_count becomes 1.
//  - reset_n asserted mid-operation: all contents are discarded immediately (asynchronous),
//    and the block returns to the reset values above.
// STRUCTURE
//  - Package result_pkg: localparams MODE_SAT=2'b00, MODE_WRAP=2'b01, MODE_ZERO=2'b10, MODE_DROP=2'b11.
//    Also holds the FIFO entry layout {flag, data} as a width function of DATA_WIDTH.
//  - Sub-module result_fifo: generic DEPTH x (DATA_WIDTH+1) synchronous FIFO with registered head,
//    valid/ready, level, full and empty.
//  - Top level: range check, mode mapping, drop gating, overflow counter.
// TESTING
//  1. Reset, W=8, DEPTH=4: push 255, then 256 in SAT -> out 0xFF/inv=0, then 0xFF/inv=1;
//     ovf_count=1.
//  2. WRAP, push 0x1_2C -> out 0x2C, inv=1. ZERO, push 0x1FF -> out 0x00, inv=1. ovf_count=2.
//  3. DROP, push 300, then 7 -> only 7 appears at the output (inv=0). ovf_count=1.
//     in_ready stays 1 throughout.
//  4. Hold out_ready=0 and push 5 beats -> after 4 beats: full=1, in_ready=0, beat 5 stalls.
//     One pop -> beat 5 accepted the next cycle. Drain gives the values in order; empty=1.
//  5. Level 1 with push and pop in the same cycle, repeated 10 cycles -> level stays 1 and every value
//     is seen once. Pointers wrap at least twice.
//  6. CNT_WIDTH=2: 5 ovf beats -> ovf_count=3. clr_count together with an ovf beat -> 1.
//     Assert reset_n mid-stream -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/result_pkg.sv
// Shared constants for the result output stage.
// Saturation mode encodings and FIFO entry layout {flag, data}.
package result_pkg;

  localparam logic [1:0] MODE_SAT  = 2'b00;
  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_ZERO = 2'b10;
  localparam logic [1:0] MODE_DROP = 2'b11;

  // Entry is {flag, data}: flag sits at bit dw.
  function automatic int entry_width(int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Generic DEPTH x WIDTH FIFO with registered head, valid/ready both sides.
// Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data, full, empty, level.
module result_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_nxt;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             pop;

  assign full      = (count == LW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign level     = count;
  assign out_data  = head;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + LW'(1);
    else if (pop && !push)
      count_nxt = count - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      // Bypass the write when the new head is the slot being written.
      if (count_nxt != '0) begin
        if (push && (rd_nxt == wr_ptr))
          head <= in_data;
        else
          head <= mem[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/result_sat_fifo.sv
// Result output stage: range check, sat/wrap/zero/drop mapping, FIFO, ovf counter.
// Ports: in_*/out_* valid/ready, sat_mode, full/empty/level, ovf_count, clr_count.
module result_sat_fifo
  import result_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 2*DATA_WIDTH+1,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     in_data,
  input  logic [1:0]              sat_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_invalid,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    ovf_count,
  input  logic                    clr_count
);

  localparam int EW = entry_width(DATA_WIDTH);

  logic          ovf;
  logic          drop;
  logic          acc_ovf;
  logic [EW-1:0] entry;
  logic [EW-1:0] head;

  assign ovf     = |in_data[IN_WIDTH-1:DATA_WIDTH];
  assign drop    = ovf && (sat_mode == MODE_DROP);
  assign acc_ovf = in_valid && in_ready && ovf;

  always_comb begin
    entry = {1'b0, in_data[DATA_WIDTH-1:0]};
    if (ovf) begin
      unique case (sat_mode)
        MODE_SAT:  entry = {1'b1, {DATA_WIDTH{1'b1}}};
        MODE_WRAP: entry = {1'b1, in_data[DATA_WIDTH-1:0]};
        MODE_ZERO: entry = {1'b1, {DATA_WIDTH{1'b0}}};
        default:   entry = {1'b1, in_data[DATA_WIDTH-1:0]};
      endcase
    end
  end

  // Dropped beats complete the handshake but never reach the FIFO.
  result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid && !drop),
    .in_ready  (in_ready),
    .in_data   (entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign out_data    = head[DATA_WIDTH-1:0];
  assign out_invalid = out_valid && head[DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_count <= '0;
    else if (clr_count)
      ovf_count <= acc_ovf ? CNT_WIDTH'(1) : '0;
    else if (acc_ovf && (ovf_count != '1))
      ovf_count <= ovf_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_result_sat_fifo.sv
// Directed bench for result_sat_fifo (W=8, DEPTH=4; second instance CNT_WIDTH=2).
// Both instances share all inputs.
module tb_result_sat_fifo;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        in_valid = 0;
  logic [16:0] in_data = '0;
  logic [1:0]  sat_mode = 2'b00;
  logic        out_ready = 0;
  logic        clr_count = 0;

  logic        in_ready, out_valid, out_invalid, full, empty;
  logic [7:0]  out_data;
  logic [2:0]  level;
  logic [7:0]  ovf_count;

  logic        in_ready1, out_valid1, out_invalid1, full1, empty1;
  logic [7:0]  out_data1;
  logic [2:0]  level1;
  logic [1:0]  ovf_count1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_sat_fifo dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sat_mode(sat_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_invalid(out_invalid),
    .full(full), .empty(empty), .level(level),
    .ovf_count(ovf_count), .clr_count(clr_count)
  );

  result_sat_fifo #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .sat_mode(sat_mode),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_invalid(out_invalid1),
    .full(full1), .empty(empty1), .level(level1),
    .ovf_count(ovf_count1), .clr_count(clr_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0;
    out_ready = 0;
    clr_count = 0;
    sat_mode = 2'b00;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic push(input logic [16:0] d, input logic [1:0] m);
    in_valid = 1;
    in_data = d;
    sat_mode = m;
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    #2;
    checks++;
    if ({out_valid, out_data, out_invalid, level, empty, full, ovf_count, in_ready}
        !== {1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h i=%b l=%0d e=%b f=%b c=%0d r=%b exp 0 00 0 0 1 0 0 1",
               out_valid, out_data, out_invalid, level, empty, full, ovf_count, in_ready);
    end
    do_reset();
  endtask

  task automatic test_sat();
    do_reset();
    push(17'd255, 2'b00);
    checks++;
    if ({out_valid, out_data, out_invalid} !== {1'b1, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL sat_255 got v=%b d=%h i=%b exp 1 ff 0", out_valid, out_data, out_invalid);
    end
    push(17'd256, 2'b00);
    checks++;
    if ({level, out_data, out_invalid} !== {3'd2, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL sat_hold got l=%0d d=%h i=%b exp 2 ff 0", level, out_data, out_invalid);
    end
    out_ready = 1;
    step();
    checks++;
    if ({out_valid, out_data, out_invalid} !== {1'b1, 8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL sat_256 got v=%b d=%h i=%b exp 1 ff 1", out_valid, out_data, out_invalid);
    end
    step();
    out_ready = 0;
    checks++;
    if ({empty, out_valid, out_invalid, out_data, ovf_count} !== {1'b1, 1'b0, 1'b0, 8'hFF, 8'd1}) begin
      failures++;
      $display("FAIL sat_empty got e=%b v=%b i=%b d=%h c=%0d exp 1 0 0 ff 1",
               empty, out_valid, out_invalid, out_data, ovf_count);
    end
  endtask

  task automatic test_wrap_zero();
    do_reset();
    push(17'h12C, 2'b01);
    push(17'h1FF, 2'b10);
    sat_mode = 2'b00;
    checks++;
    if ({out_data, out_invalid} !== {8'h2C, 1'b1}) begin
      failures++;
      $display("FAIL wrap got d=%h i=%b exp 2c 1", out_data, out_invalid);
    end
    out_ready = 1;
    step();
    checks++;
    if ({out_valid, out_data, out_invalid} !== {1'b1, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL zero got v=%b d=%h i=%b exp 1 00 1", out_valid, out_data, out_invalid);
    end
    step();
    out_ready = 0;
    checks++;
    if (ovf_count !== 8'd2) begin
      failures++;
      $display("FAIL wrap_zero_cnt got %0d exp 2", ovf_count);
    end
  endtask

  task automatic test_drop();
    do_reset();
    in_valid = 1;
    in_data = 17'd300;
    sat_mode = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drop_ready got %b exp 1", in_ready);
    end
    step();
    in_valid = 0;
    checks++;
    if ({out_valid, empty, level, ovf_count, in_ready} !== {1'b0, 1'b1, 3'd0, 8'd1, 1'b1}) begin
      failures++;
      $display("FAIL drop_300 got v=%b e=%b l=%0d c=%0d r=%b exp 0 1 0 1 1",
               out_valid, empty, level, ovf_count, in_ready);
    end
    push(17'd7, 2'b11);
    checks++;
    if ({out_valid, out_data, out_invalid, level, ovf_count} !== {1'b1, 8'h07, 1'b0, 3'd1, 8'd1}) begin
      failures++;
      $display("FAIL drop_7 got v=%b d=%h i=%b l=%0d c=%0d exp 1 07 0 1 1",
               out_valid, out_data, out_invalid, level, ovf_count);
    end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 17'(10 + i);
      step();
    end
    in_data = 17'd14;
    checks++;
    if ({full, in_ready, level} !== {1'b1, 1'b0, 3'd4}) begin
      failures++;
      $display("FAIL full_flags got f=%b r=%b l=%0d exp 1 0 4", full, in_ready, level);
    end
    step();
    checks++;
    if ({level, out_data} !== {3'd4, 8'd10}) begin
      failures++;
      $display("FAIL full_stall got l=%0d d=%0d exp 4 10", level, out_data);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if ({level, in_ready, out_data} !== {3'd3, 1'b1, 8'd11}) begin
      failures++;
      $display("FAIL full_pop got l=%0d r=%b d=%0d exp 3 1 11", level, in_ready, out_data);
    end
    step();
    in_valid = 0;
    checks++;
    if ({level, full} !== {3'd4, 1'b1}) begin
      failures++;
      $display("FAIL full_beat5 got l=%0d f=%b exp 4 1", level, full);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 8'(11 + i)}) begin
        failures++;
        $display("FAIL drain_%0d got v=%b d=%0d exp 1 %0d", i, out_valid, out_data, 11 + i);
      end
      step();
    end
    out_ready = 0;
    checks++;
    if ({empty, out_valid} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL drain_empty got e=%b v=%b exp 1 0", empty, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(17'd100, 2'b00);
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 17'(101 + i);
      checks++;
      if ({out_valid, out_data} !== {1'b1, 8'(100 + i)}) begin
        failures++;
        $display("FAIL b2b_head_%0d got v=%b d=%0d exp 1 %0d", i, out_valid, out_data, 100 + i);
      end
      step();
      checks++;
      if (level !== 3'd1) begin
        failures++;
        $display("FAIL b2b_level_%0d got %0d exp 1", i, level);
      end
    end
    in_valid = 0;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'd110}) begin
      failures++;
      $display("FAIL b2b_last got v=%b d=%0d exp 1 110", out_valid, out_data);
    end
    step();
    out_ready = 0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_counter_reset();
    do_reset();
    out_ready = 1;
    sat_mode = 2'b00;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 17'(256 + i);
      step();
    end
    in_valid = 0;
    checks++;
    if ({ovf_count1, ovf_count} !== {2'd3, 8'd5}) begin
      failures++;
      $display("FAIL cnt_sat got c2=%0d c8=%0d exp 3 5", ovf_count1, ovf_count);
    end
    clr_count = 1;
    in_valid = 1;
    in_data = 17'h1FF;
    step();
    clr_count = 0;
    in_valid = 0;
    checks++;
    if ({ovf_count1, ovf_count} !== {2'd1, 8'd1}) begin
      failures++;
      $display("FAIL cnt_clr_ovf got c2=%0d c8=%0d exp 1 1", ovf_count1, ovf_count);
    end
    step();
    step();
    out_ready = 0;
    push(17'd3, 2'b00);
    push(17'd4, 2'b00);
    checks++;
    if (level !== 3'd2) begin
      failures++;
      $display("FAIL pre_reset_level got %0d exp 2", level);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if ({out_valid, out_data, out_invalid, level, empty, full, ovf_count, ovf_count1}
        !== {1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL async_reset got v=%b d=%h i=%b l=%0d e=%b f=%b c8=%0d c2=%0d exp 0 00 0 0 1 0 0 0",
               out_valid, out_data, out_invalid, level, empty, full, ovf_count, ovf_count1);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sat();
    test_wrap_zero();
    test_drop();
    test_full();
    test_back_to_back();
    test_counter_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
